blk_timing_gen: RTL and testbench

- Generates the block-grid strobes that drive the per-block statistics buffer: `h_save_o` at each block's last pixel, `v_save_o` after each block row.
- Derives them from raw video timing (`de_i`, `vs_i`) and forwards pixel data with matching latency.
- Sits between the video input front-end and the block statistics/flag buffer.
- Also flags frames whose geometry does not match the configured grid.

---
 rtl/blk_timing_gen_pkg.sv | 20 ++
 rtl/wrap_counter.sv | 26 ++
 rtl/blk_timing_gen.sv | 121 ++++++++++++
 tb/tb_blk_timing_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/blk_timing_gen_pkg.sv
// rtl/blk_timing_gen_pkg.sv - grid constants, state type and width helper for the block timing generator
package blk_timing_gen_pkg;

   localparam int unsigned HBLKS = 10;
   localparam int unsigned VBLKS = 10;
   localparam int unsigned BLK_W = 30;
   localparam int unsigned BLK_H = 30;
   localparam int unsigned PXS   = BLK_W * BLK_H;

   typedef enum logic [1:0] {
      SYNC,
      ACTIVE,
      OVER
   } state_t;

   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - modulo-MAX counter with synchronous clear and a wrap pulse
module wrap_counter #(
   parameter int unsigned MAX   = 2,
   parameter int unsigned WIDTH = (MAX > 1) ? $clog2(MAX) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] value,
   output logic             wrap
);

   assign wrap = inc && (value == WIDTH'(MAX - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         value <= '0;
      end else if (clear) begin
         value <= '0;
      end else if (inc) begin
         value <= wrap ? '0 : value + 1'b1;
      end
   end

endmodule

// File: rtl/blk_timing_gen.sv
// rtl/blk_timing_gen.sv - block-grid save strobes and geometry check derived from de/vs timing
module blk_timing_gen #(
   parameter int unsigned HBLKS = blk_timing_gen_pkg::HBLKS,
   parameter int unsigned VBLKS = blk_timing_gen_pkg::VBLKS,
   parameter int unsigned BLK_W = blk_timing_gen_pkg::BLK_W,
   parameter int unsigned BLK_H = blk_timing_gen_pkg::BLK_H
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       de_i,
   input  logic                       vs_i,
   input  logic [23:0]                wd_i,
   output logic                       de_o,
   output logic [23:0]                wd_o,
   output logic                       h_save_o,
   output logic                       v_save_o,
   output logic [$clog2(HBLKS)-1:0]   blk_x_o,
   output logic [$clog2(VBLKS)-1:0]   blk_y_o,
   output logic                       frame_o,
   output logic                       geom_err_o
);
   import blk_timing_gen_pkg::*;

   localparam int unsigned PW      = cnt_w(BLK_W);
   localparam int unsigned XW      = cnt_w(HBLKS);
   localparam int unsigned LW      = cnt_w(BLK_H);
   localparam int unsigned YW      = cnt_w(VBLKS);
   localparam int unsigned LINE_PX = HBLKS * BLK_W;
   localparam int unsigned TW      = $clog2(LINE_PX + 1) + 1;

   state_t        state;
   logic          de_q, vs_q, frame_pend, line_done;
   logic [TW-1:0] tot_px;
   logic [PW-1:0] px_cnt;
   logic [XW-1:0] bx_cnt;
   logic [LW-1:0] ln_cnt;
   logic [YW-1:0] by_cnt;
   logic          px_wrap, bx_wrap, ln_wrap, by_wrap;
   logic          vs_rise, de_fall, act, line_end;

   assign vs_rise  = vs_i & ~vs_q;
   assign de_fall  = de_q & ~de_i;
   assign act      = (state == ACTIVE) & ~vs_rise;
   assign line_end = vs_rise | de_fall;

   wrap_counter #(.MAX(BLK_W), .WIDTH(PW)) u_px (
      .clk_i(clk_i), .rst_i(rst_i), .clear(line_end), .inc(act & de_i),
      .value(px_cnt), .wrap(px_wrap));

   // bx keeps wrapping on over-long lines; line_done holds the reported column at the last block
   wrap_counter #(.MAX(HBLKS), .WIDTH(XW)) u_bx (
      .clk_i(clk_i), .rst_i(rst_i), .clear(line_end), .inc(px_wrap),
      .value(bx_cnt), .wrap(bx_wrap));

   wrap_counter #(.MAX(BLK_H), .WIDTH(LW)) u_ln (
      .clk_i(clk_i), .rst_i(rst_i), .clear(vs_rise), .inc(act & de_fall),
      .value(ln_cnt), .wrap(ln_wrap));

   wrap_counter #(.MAX(VBLKS), .WIDTH(YW)) u_by (
      .clk_i(clk_i), .rst_i(rst_i), .clear(vs_rise), .inc(ln_wrap),
      .value(by_cnt), .wrap(by_wrap));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= SYNC;
         de_q       <= 1'b0;
         vs_q       <= 1'b0;
         frame_pend <= 1'b0;
         line_done  <= 1'b0;
         tot_px     <= '0;
         de_o       <= 1'b0;
         wd_o       <= '0;
         h_save_o   <= 1'b0;
         v_save_o   <= 1'b0;
         blk_x_o    <= '0;
         blk_y_o    <= '0;
         frame_o    <= 1'b0;
         geom_err_o <= 1'b0;
      end else begin
         de_q     <= de_i;
         vs_q     <= vs_i;
         de_o     <= de_i;
         wd_o     <= wd_i;
         h_save_o <= px_wrap & ~line_done;
         v_save_o <= ln_wrap;
         blk_x_o  <= line_done ? ($clog2(HBLKS))'(HBLKS - 1) : ($clog2(HBLKS))'(bx_cnt);
         blk_y_o  <= ($clog2(VBLKS))'(by_cnt);
         frame_o  <= act & de_i & frame_pend;

         if (line_end) begin
            tot_px    <= '0;
            line_done <= 1'b0;
         end else begin
            if (act && de_i && (tot_px != '1)) tot_px <= tot_px + 1'b1;
            if (bx_wrap) line_done <= 1'b1;
         end

         if (act && de_i) frame_pend <= 1'b0;

         if (vs_rise) begin
            frame_pend <= 1'b1;
            state      <= ACTIVE;
            if ((state == ACTIVE) || de_i) geom_err_o <= 1'b1;
         end else begin
            case (state)
               ACTIVE: begin
                  if (de_fall) begin
                     if (tot_px != TW'(LINE_PX)) geom_err_o <= 1'b1;
                     if (by_wrap) state <= OVER;
                  end
               end
               OVER: begin
                  if (de_i) geom_err_o <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_blk_timing_gen.sv
// tb/tb_blk_timing_gen.sv - randomized directed bench for blk_timing_gen against a pixel/line index model
module tb_blk_timing_gen;

   localparam int HB = 4;
   localparam int VB = 3;
   localparam int BW = 5;
   localparam int BH = 2;
   localparam int LINE_PX  = HB * BW;
   localparam int FRAME_LN = VB * BH;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        de_i  = 1'b0;
   logic        vs_i  = 1'b0;
   logic [23:0] wd_i  = '0;
   logic        de_o, h_save_o, v_save_o, frame_o, geom_err_o;
   logic [23:0] wd_o;
   logic [1:0]  blk_x_o, blk_y_o;

   blk_timing_gen #(.HBLKS(HB), .VBLKS(VB), .BLK_W(BW), .BLK_H(BH)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .de_i(de_i), .vs_i(vs_i), .wd_i(wd_i),
      .de_o(de_o), .wd_o(wd_o), .h_save_o(h_save_o), .v_save_o(v_save_o),
      .blk_x_o(blk_x_o), .blk_y_o(blk_y_o), .frame_o(frame_o), .geom_err_o(geom_err_o));

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_fail = 0;
   int h_cnt, v_cnt, first_h;

   // model: armed after first vs edge; lines past FRAME_LN are the over-long region
   bit m_armed, m_err, m_fpend, m_de_prev, m_vs_prev;
   int m_line, m_px;
   logic [31:0] e_de, e_wd, e_h, e_v, e_f, e_x, e_y;
   bit e_chk_xy;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_step();
      bit vs_rise;
      e_h = 0; e_v = 0; e_f = 0; e_x = 0; e_y = 0; e_chk_xy = 0;
      if (rst_i) begin
         m_armed = 0; m_err = 0; m_fpend = 0; m_de_prev = 0; m_vs_prev = 0;
         m_line = 0; m_px = 0;
         e_de = 0; e_wd = 0; e_chk_xy = 1;
         return;
      end
      e_de = 32'(de_i);
      e_wd = 32'(wd_i);
      vs_rise = vs_i && !m_vs_prev;
      if (vs_rise) begin
         if ((m_armed && m_line < FRAME_LN) || de_i) m_err = 1;
         m_armed = 1; m_line = 0; m_px = 0; m_fpend = 1;
      end else if (m_armed) begin
         if (de_i) begin
            if (m_line < FRAME_LN) begin
               e_h = ((m_px % BW == BW - 1) && (m_px < LINE_PX)) ? 1 : 0;
               e_x = (m_px / BW < HB) ? m_px / BW : HB - 1;
               e_y = m_line / BH;
               e_chk_xy = 1;
               e_f = m_fpend ? 1 : 0;
               m_fpend = 0;
               m_px++;
            end else begin
               m_err = 1;
            end
         end else if (m_de_prev) begin
            if (m_line < FRAME_LN) begin
               if (m_px != LINE_PX) m_err = 1;
               e_v = (m_line % BH == BH - 1) ? 1 : 0;
               m_line++;
            end
            m_px = 0;
         end
      end
      m_de_prev = de_i;
      m_vs_prev = vs_i;
   endtask

   task automatic cyc(input logic de, input logic vs);
      de_i = de;
      vs_i = vs;
      wd_i = 24'($urandom);
      @(posedge clk_i);
      model_step();
      #1;
      check("de_o", 32'(de_o), e_de);
      check("wd_o", 32'(wd_o), e_wd);
      check("h_save", 32'(h_save_o), e_h);
      check("v_save", 32'(v_save_o), e_v);
      check("frame", 32'(frame_o), e_f);
      check("geom_err", 32'(geom_err_o), 32'(m_err));
      if (e_chk_xy) begin
         check("blk_x", 32'(blk_x_o), e_x);
         check("blk_y", 32'(blk_y_o), e_y);
      end
      if (h_save_o === 1'b1) h_cnt++;
      if (v_save_o === 1'b1) v_cnt++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
   endtask

   task automatic vs_pulse();
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b1);
      idle(int'($urandom_range(1, 3)));
   endtask

   task automatic send_line(input int len);
      for (int p = 0; p < len; p++) begin
         cyc(1'b1, 1'b0);
         if (h_save_o === 1'b1 && first_h < 0) first_h = p + 1;
      end
      idle(int'($urandom_range(2, 4)));
   endtask

   task automatic send_lines(input int n);
      for (int l = 0; l < n; l++) send_line(LINE_PX);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      rst_i = 1'b0;
      idle(2);
      h_cnt = 0; v_cnt = 0;
   endtask

   initial begin
      first_h = -1;
      do_reset();
      send_line(LINE_PX);
      check("no_strobe_before_vs", 32'(h_cnt + v_cnt), 0);

      h_cnt = 0; v_cnt = 0;
      vs_pulse();
      send_lines(FRAME_LN);
      check("frame1_h_total", 32'(h_cnt), 24);
      check("frame1_v_total", 32'(v_cnt), 3);
      vs_pulse();
      send_lines(FRAME_LN);
      check("frame2_h_total", 32'(h_cnt), 48);
      check("frame2_v_total", 32'(v_cnt), 6);
      check("wellformed_geom", 32'(geom_err_o), 0);

      do_reset();
      vs_pulse();
      send_line(22);
      check("long_line_h", 32'(h_cnt), 4);
      check("long_line_geom", 32'(geom_err_o), 1);

      do_reset();
      vs_pulse();
      send_line(18);
      check("short_line_h", 32'(h_cnt), 3);
      check("short_line_geom", 32'(geom_err_o), 1);

      do_reset();
      vs_pulse();
      send_lines(4);
      check("short_frame_v", 32'(v_cnt), 2);
      vs_pulse();
      check("short_frame_geom", 32'(geom_err_o), 1);
      v_cnt = 0;
      send_lines(FRAME_LN);
      check("after_short_v", 32'(v_cnt), 3);

      do_reset();
      vs_pulse();
      send_lines(FRAME_LN + 1);
      check("long_frame_h", 32'(h_cnt), 24);
      check("long_frame_v", 32'(v_cnt), 3);
      check("long_frame_geom", 32'(geom_err_o), 1);

      do_reset();
      idle(2);
      cyc(1'b1, 1'b1);
      for (int p = 0; p < LINE_PX; p++) cyc(1'b1, 1'b0);
      idle(3);
      check("vs_with_de_h", 32'(h_cnt), 4);

      do_reset();
      vs_pulse();
      for (int p = 0; p < 7; p++) cyc(1'b1, 1'b0);
      rst_i = 1'b1;
      #1;
      check("rst_de_o", 32'(de_o), 0);
      check("rst_wd_o", 32'(wd_o), 0);
      check("rst_h_save", 32'(h_save_o), 0);
      check("rst_blk_x", 32'(blk_x_o), 0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b0);
      rst_i = 1'b0;
      idle(2);
      for (int p = 0; p < 4; p++) cyc(1'b1, 1'b0);
      idle(2);
      first_h = -1;
      vs_pulse();
      send_line(LINE_PX);
      check("first_h_after_reset", 32'(first_h), 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
